// File: rtl/cpu_pkg.sv
// cpu_pkg: opcode and FSM state types plus wait-status codes shared by the multicycle CPU
package cpu_pkg;
  typedef enum logic [3:0] {
    NOP = 4'h0, LDI, LDR, STR, ADD, SUB, AND, OR,
    IN, OUT, JMP, JZ, WAIT0, WAIT1, RSVD, HALT
  } cpu_op_t;
  typedef enum logic [1:0] {FETCH, DECODE, EXEC, HALTED} cpu_state_t;
  localparam logic [1:0] WAIT0_CODE = 2'b01;
  localparam logic [1:0] WAIT1_CODE = 2'b10;
endpackage

// File: rtl/cpu_regfile.sv
// cpu_regfile: NREG x n register file, combinational read, synchronous write, async clear
module cpu_regfile #(
  parameter int n = 8,
  parameter int NREG = 4,
  localparam int RW = (NREG > 1) ? $clog2(NREG) : 1
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  input  logic          i_we,
  input  logic [RW-1:0] i_waddr,
  input  logic [n-1:0]  i_wdata,
  input  logic [RW-1:0] i_raddr,
  output logic [n-1:0]  o_rdata
);
  logic [n-1:0] r_mem [NREG];
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) r_mem <= '{default: '0};
    else if (i_we) r_mem[i_waddr] <= i_wdata;
  assign o_rdata = r_mem[i_raddr];
endmodule

// File: rtl/cpu_multicycle.sv
// cpu_multicycle: parametrised accumulator CPU, FETCH/DECODE/EXEC FSM over an external sync ROM
module cpu_multicycle
  import cpu_pkg::*;
#(
  parameter int n = 8,
  parameter int AW = 8,
  parameter int NREG = 4
) (
  input  logic          Clock,
  input  logic          nReset,
  input  logic [n:0]    Switches,
  input  logic [n+3:0]  ImemData,
  output logic [AW-1:0] ImemAddr,
  output logic [n-1:0]  LEDs,
  output logic [1:0]    Waiting,
  output logic          Halted
);
  localparam int RW = (NREG > 1) ? $clog2(NREG) : 1;
  cpu_state_t r_state, w_state_nxt;
  cpu_op_t w_op;
  logic [AW-1:0] r_pc, w_pc_nxt;
  logic [n+3:0] r_ir;
  logic [n-1:0] r_acc, w_acc_nxt, r_leds, w_rd, w_imm;
  logic [n:0] r_sync1, r_sync2;
  logic r_z, r_c, w_c_nxt, w_acc_we, w_rf_we, w_led_we, w_go;
  assign w_op = cpu_op_t'(r_ir[n+3:n]);
  assign w_imm = r_ir[n-1:0];
  assign w_go = r_sync2[n];
  assign ImemAddr = r_pc;
  assign LEDs = r_leds;
  assign Halted = r_state == HALTED;
  cpu_regfile #(.n(n), .NREG(NREG)) u_rf (
    .i_clk(Clock),
    .i_rst_n(nReset),
    .i_we(w_rf_we),
    .i_waddr(w_imm[RW-1:0]),
    .i_wdata(r_acc),
    .i_raddr(w_imm[RW-1:0]),
    .o_rdata(w_rd)
  );
  always_ff @(posedge Clock or negedge nReset)
    if (!nReset) begin
      r_state <= FETCH;
      r_pc <= '0;
      r_ir <= '0;
      r_acc <= '0;
      r_z <= 1'b1;
      r_c <= 1'b0;
      r_leds <= '0;
      r_sync1 <= '0;
      r_sync2 <= '0;
    end else begin
      r_sync1 <= Switches;
      r_sync2 <= r_sync1;
      r_state <= w_state_nxt;
      r_pc <= w_pc_nxt;
      r_c <= w_c_nxt;
      if (r_state == DECODE) r_ir <= ImemData;
      if (w_acc_we) r_acc <= w_acc_nxt;
      if (w_acc_we) r_z <= w_acc_nxt == '0;
      if (w_led_we) r_leds <= r_acc;
    end
  always_comb begin
    w_state_nxt = r_state;
    w_pc_nxt = r_pc;
    w_acc_nxt = r_acc;
    w_c_nxt = r_c;
    w_acc_we = 1'b0;
    w_rf_we = 1'b0;
    w_led_we = 1'b0;
    Waiting = 2'b00;
    case (r_state)
      FETCH: w_state_nxt = DECODE;
      DECODE: w_state_nxt = EXEC;
      EXEC: begin
        w_state_nxt = FETCH;
        w_pc_nxt = r_pc + 1'b1;
        w_acc_we = w_op inside {LDI, LDR, ADD, SUB, AND, OR, IN};
        case (w_op)
          LDI: w_acc_nxt = w_imm;
          LDR: w_acc_nxt = w_rd;
          STR: w_rf_we = 1'b1;
          ADD: {w_c_nxt, w_acc_nxt} = {1'b0, r_acc} + {1'b0, w_rd};
          SUB: {w_c_nxt, w_acc_nxt} = {1'b0, r_acc} - {1'b0, w_rd};
          AND: w_acc_nxt = r_acc & w_rd;
          OR: w_acc_nxt = r_acc | w_rd;
          IN: w_acc_nxt = r_sync2[n-1:0];
          OUT: w_led_we = 1'b1;
          JMP: w_pc_nxt = AW'(w_imm);
          JZ: w_pc_nxt = r_z ? AW'(w_imm) : r_pc + 1'b1;
          // stall while go differs from the level the WAIT variant asks for
          WAIT0, WAIT1: if (w_go != (w_op == WAIT1)) begin
            w_state_nxt = EXEC;
            w_pc_nxt = r_pc;
            Waiting = (w_op == WAIT0) ? WAIT0_CODE : WAIT1_CODE;
          end
          HALT: begin
            w_state_nxt = HALTED;
            w_pc_nxt = r_pc;
          end
          default: ;
        endcase
      end
      default: ;
    endcase
  end
endmodule

// File: tb/tb_cpu_multicycle.sv
// tb_cpu_multicycle: table vectors, hand-written multi-cycle sequences and a randomized ISA-level model
module tb_cpu_multicycle;
  logic Clock = 1'b0;
  logic nReset = 1'b0;
  logic [8:0] Switches = '0;
  logic [11:0] ImemData = '0;
  logic [7:0] ImemAddr, LEDs;
  logic [1:0] Waiting;
  logic Halted;
  logic [3:0] addr4;
  logic [7:0] leds4;
  logic [1:0] wait4;
  logic halt4;
  logic [11:0] rom [256];
  logic [11:0] prog [$];
  logic [11:0] ins;
  logic go;
  int vecs = 0;
  int errs = 0;
  int m_pc, m_acc, m_z, m_c, m_leds, m_sw;
  int m_reg [4];
  int a1 [12] = '{0, 0, 0, 1, 1, 1, 2, 2, 2, 2, 2, 2};
  typedef struct {
    logic [3:0] op;
    logic [7:0] r;
    logic [7:0] acc;
    logic [7:0] led;
    logic z;
  } vec_t;
  vec_t tbl [11];

  always #5 Clock = ~Clock;
  always @(posedge Clock) ImemData <= rom[ImemAddr];

  cpu_multicycle dut (
    .Clock(Clock), .nReset(nReset), .Switches(Switches), .ImemData(ImemData),
    .ImemAddr(ImemAddr), .LEDs(LEDs), .Waiting(Waiting), .Halted(Halted)
  );
  cpu_multicycle #(.n(8), .AW(4), .NREG(4)) dut4 (
    .Clock(Clock), .nReset(nReset), .Switches(9'h000), .ImemData(12'h000),
    .ImemAddr(addr4), .LEDs(leds4), .Waiting(wait4), .Halted(halt4)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vecs++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic load();
    foreach (rom[i]) rom[i] = 12'hF00;
    foreach (prog[i]) rom[i] = prog[i];
  endtask

  task automatic do_reset();
    @(negedge Clock);
    nReset = 1'b0;
    @(negedge Clock);
    nReset = 1'b1;
  endtask

  task automatic step(input int k);
    repeat (k) @(negedge Clock);
  endtask

  task automatic run_to_halt(input int budget);
    int t = 0;
    while (Halted !== 1'b1 && t < budget) begin
      @(negedge Clock);
      t++;
    end
    chk("halt_budget", 32'(Halted), 1);
  endtask

  task automatic model_exec();
    int op = int'(rom[m_pc][11:8]);
    int imm = int'(rom[m_pc][7:0]);
    int r = m_reg[imm % 4];
    int nxt = (m_pc + 1) % 256;
    case (op)
      1: m_acc = imm;
      2: m_acc = r;
      3: m_reg[imm % 4] = m_acc;
      4: begin m_c = int'(m_acc + r > 255); m_acc = (m_acc + r) % 256; end
      5: begin m_c = int'(m_acc < r); m_acc = (m_acc - r + 256) % 256; end
      6: m_acc = m_acc & r;
      7: m_acc = m_acc | r;
      8: m_acc = m_sw;
      9: m_leds = m_acc;
      10: nxt = imm;
      11: if (m_z != 0) nxt = imm;
      default: ;
    endcase
    if (op inside {1, 2, 4, 5, 6, 7, 8}) m_z = int'(m_acc == 0);
    m_pc = nxt;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    tbl[0]  = '{4'h4, 8'h01, 8'hFF, 8'h00, 1'b1};
    tbl[1]  = '{4'h4, 8'h34, 8'h12, 8'h46, 1'b0};
    tbl[2]  = '{4'h5, 8'h03, 8'h05, 8'h02, 1'b0};
    tbl[3]  = '{4'h5, 8'h05, 8'h03, 8'hFE, 1'b0};
    tbl[4]  = '{4'h5, 8'h77, 8'h77, 8'h00, 1'b1};
    tbl[5]  = '{4'h6, 8'h3C, 8'hF0, 8'h30, 1'b0};
    tbl[6]  = '{4'h6, 8'hF0, 8'h0F, 8'h00, 1'b1};
    tbl[7]  = '{4'h7, 8'h0F, 8'hF0, 8'hFF, 1'b0};
    tbl[8]  = '{4'h7, 8'h00, 8'h00, 8'h00, 1'b1};
    tbl[9]  = '{4'h2, 8'hA5, 8'h00, 8'hA5, 1'b0};
    tbl[10] = '{4'h2, 8'h00, 8'h5A, 8'h00, 1'b1};
    prog = '{12'h105, 12'h900, 12'hF00};
    load();
    step(2);
    chk("reset_outs", 32'({ImemAddr, LEDs, Waiting, Halted}), 0);
    do_reset();
    for (int t = 0; t < 12; t++) begin
      chk($sformatf("t1_addr_c%0d", t), 32'(ImemAddr), a1[t]);
      chk($sformatf("t1_leds_c%0d", t), 32'(LEDs), t >= 6 ? 5 : 0);
      chk($sformatf("t1_halt_c%0d", t), 32'(Halted), t >= 9 ? 1 : 0);
      step(1);
    end
    prog = '{12'h1FF, 12'h301, 12'h101, 12'h401, 12'h501, 12'hF00};
    load();
    do_reset();
    step(12);
    chk("t2_add_acc_c_z", 32'({dut.r_acc, dut.r_c, dut.r_z}), 32'({8'h00, 1'b1, 1'b1}));
    step(3);
    chk("t2_sub_acc_c_z", 32'({dut.r_acc, dut.r_c, dut.r_z}), 32'({8'h01, 1'b1, 1'b0}));
    Switches = 9'h000;
    prog = '{12'hD00, 12'hF00};
    load();
    do_reset();
    step(2);
    for (int t = 0; t < 20; t++) begin
      chk($sformatf("t3_stall_%0d", t), 32'({ImemAddr, Waiting}), 32'({8'h00, 2'b10}));
      step(1);
    end
    Switches = 9'h100;
    step(1);
    chk("t3_sync1", 32'({ImemAddr, Waiting}), 32'({8'h00, 2'b10}));
    step(1);
    chk("t3_sync2", 32'({ImemAddr, Waiting}), 32'({8'h00, 2'b00}));
    step(1);
    chk("t3_advance", 32'({ImemAddr, Waiting}), 32'({8'h01, 2'b00}));
    Switches = 9'h000;
    prog = '{12'h100, 12'hB40};
    load();
    do_reset();
    step(6);
    chk("t4_jz_taken", 32'(ImemAddr), 32'h40);
    prog = '{12'h101, 12'hB40};
    load();
    do_reset();
    step(6);
    chk("t4_jz_fall", 32'(ImemAddr), 32'h02);
    do_reset();
    for (int t = 0; t < 60; t++) begin
      chk($sformatf("t5_addr_c%0d", t), 32'(addr4), (t / 3) % 16);
      chk($sformatf("t5_noX_c%0d", t), 32'(!$isunknown({addr4, leds4, wait4, halt4})), 1);
      step(1);
    end
    Switches = 9'h100;
    prog = '{12'h107, 12'h900, 12'hC00};
    load();
    do_reset();
    step(12);
    chk("t6_in_wait0", 32'({ImemAddr, LEDs, Waiting, Halted}), 32'({8'h02, 8'h07, 2'b01, 1'b0}));
    #2 nReset = 1'b0;
    #1 chk("t6_async_rst_wait", 32'({ImemAddr, LEDs, Waiting, Halted}), 0);
    Switches = 9'h000;
    @(negedge Clock);
    nReset = 1'b1;
    chk("t6_restart_a", 32'(ImemAddr), 0);
    run_to_halt(60);
    chk("t6_halted", 32'({ImemAddr, LEDs, Waiting, Halted}), 32'({8'h03, 8'h07, 2'b00, 1'b1}));
    #2 nReset = 1'b0;
    #1 chk("t6_async_rst_halt", 32'({ImemAddr, LEDs, Waiting, Halted}), 0);
    @(negedge Clock);
    nReset = 1'b1;
    chk("t6_restart_b0", 32'(ImemAddr), 0);
    step(3);
    chk("t6_restart_b1", 32'(ImemAddr), 1);
    foreach (tbl[i]) begin
      prog = '{{4'h1, tbl[i].r}, 12'h302, {4'h1, tbl[i].acc}, {tbl[i].op, 8'h02}, 12'h900, 12'hB80, 12'hF00};
      load();
      do_reset();
      run_to_halt(60);
      chk($sformatf("tbl%0d_leds", i), 32'(LEDs), 32'(tbl[i].led));
      chk($sformatf("tbl%0d_addr", i), 32'(ImemAddr), tbl[i].z ? 32'h80 : 32'h06);
    end
    for (int p = 0; p < 8; p++) begin
      go = 1'($urandom_range(0, 1));
      m_sw = int'($urandom_range(0, 255));
      Switches = {go, 8'(m_sw)};
      foreach (rom[i]) begin
        ins = 12'($urandom);
        if (ins[11:8] == 4'hF || (ins[11:8] == 4'hC && go) || (ins[11:8] == 4'hD && !go)) ins[11:8] = 4'h0;
        rom[i] = ins;
      end
      do_reset();
      m_pc = 0;
      m_acc = 0;
      m_z = 1;
      m_c = 0;
      m_leds = 0;
      foreach (m_reg[i]) m_reg[i] = 0;
      for (int k = 0; k < 50; k++) begin
        chk($sformatf("rnd_p%0d_i%0d", p, k), 32'({ImemAddr, LEDs, Waiting, Halted}),
            32'({8'(m_pc), 8'(m_leds), 3'b000}));
        model_exec();
        step(3);
      end
    end
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
